// File: rtl/charlieplex_scanner_if.sv
// Frame-load handshake between the time-formatting logic and the scanner.
// The producer drives data/valid; the scanner answers with ready (shadow buffer empty).
interface charlieplex_scanner_if #(
   parameter int PINS = 6
);
   logic [PINS*(PINS-1)-1:0] frame_data;
   logic                     frame_valid;
   logic                     frame_ready;

   modport master (output frame_data, output frame_valid, input frame_ready);
   modport slave  (input frame_data, input frame_valid, output frame_ready);
endinterface

// File: rtl/charlieplex_scanner.sv
// Charlieplexed LED matrix scanner: double-buffered frame, programmable row dwell,
// per-row blanking cycle, PWM brightness and scan enable. Pads see separate out/oe.
module charlieplex_scanner #(
   parameter int PINS        = 6,
   parameter int DWELL_BITS  = 8,
   parameter int BRIGHT_BITS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable_i,
   input  logic [DWELL_BITS-1:0]  dwell_i,
   input  logic [BRIGHT_BITS-1:0] brightness_i,
   charlieplex_scanner_if.slave   fb,
   output logic                   frame_start_o,
   output logic [PINS-1:0]        pin_out_o,
   output logic [PINS-1:0]        pin_oe_o
);
   localparam int NPIX = PINS*(PINS-1);
   localparam int COLS = PINS-1;
   localparam int RW   = $clog2(PINS);
   localparam logic [RW-1:0] LAST_ROW = RW'(PINS-1);

   logic [RW-1:0]         row_q, row_d;
   logic [DWELL_BITS-1:0] cnt_q, cnt_d;
   logic [NPIX-1:0]       active_q, active_d;
   logic [NPIX-1:0]       shadow_q, shadow_d;
   logic                  shadow_full_q, shadow_full_d;
   logic                  frame_start_q, frame_start_d;
   logic [PINS-1:0]       pin_out_q, pin_out_d;
   logic [PINS-1:0]       pin_oe_q, pin_oe_d;

   logic row_end, boundary, accept, lit;

   // Dwell compare is live so shortening dwell mid-row ends the row at once.
   assign row_end  = (cnt_q >= dwell_i);
   assign boundary = enable_i & row_end & (row_q == LAST_ROW);
   assign accept   = fb.frame_valid & ~shadow_full_q;
   assign lit      = (&brightness_i) | (cnt_q <= DWELL_BITS'(brightness_i));

   assign fb.frame_ready = ~shadow_full_q;
   assign frame_start_o  = frame_start_q;
   assign pin_out_o      = pin_out_q;
   assign pin_oe_o       = pin_oe_q;

   always_comb begin
      row_d = row_q;
      cnt_d = cnt_q;
      if (enable_i) begin
         if (row_end) begin
            cnt_d = '0;
            row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Swap looks at the pre-edge shadow_full, so a frame captured on the
   // boundary edge waits a whole frame; accept and swap are mutually exclusive.
   always_comb begin
      active_d      = active_q;
      shadow_d      = shadow_q;
      shadow_full_d = shadow_full_q;
      frame_start_d = boundary;
      if (boundary && shadow_full_q) begin
         active_d      = shadow_q;
         shadow_full_d = 1'b0;
      end
      if (accept) begin
         shadow_d      = fb.frame_data;
         shadow_full_d = 1'b1;
      end
   end

   // Row r sources on pin r; column c sinks on pin c, skipping the source pin.
   always_comb begin
      pin_oe_d  = '0;
      pin_out_d = '0;
      if (enable_i && cnt_q != '0) begin
         for (int r = 0; r < PINS; r++) begin
            if (row_q == RW'(r)) begin
               pin_oe_d[r]  = 1'b1;
               pin_out_d[r] = 1'b1;
               for (int c = 0; c < COLS; c++) begin
                  if (active_q[r*COLS + c] && lit)
                     pin_oe_d[(c < r) ? c : c + 1] = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q         <= '0;
         cnt_q         <= '0;
         active_q      <= '0;
         shadow_q      <= '0;
         shadow_full_q <= 1'b0;
         frame_start_q <= 1'b0;
         pin_out_q     <= '0;
         pin_oe_q      <= '0;
      end else begin
         row_q         <= row_d;
         cnt_q         <= cnt_d;
         active_q      <= active_d;
         shadow_q      <= shadow_d;
         shadow_full_q <= shadow_full_d;
         frame_start_q <= frame_start_d;
         pin_out_q     <= pin_out_d;
         pin_oe_q      <= pin_oe_d;
      end
   end
endmodule
